irq_ctrl: RTL and testbench

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_pkg.sv | 22 ++
 rtl/irq_timer.sv | 37 +++
 rtl/irq_ctrl.sv | 149 ++++++++++++++
 tb/tb_irq_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
//------------------------------------------------------------------------------
// Module      : irq_pkg
// Description : Shared types and constants for the interrupt controller.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package irq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SAVE_PC   = 2'd1,
        ST_SAVE_PEND = 2'd2,
        ST_ACTIVE    = 2'd3
    } irq_state_t;

    localparam logic QREG_PC   = 1'b0;
    localparam logic QREG_PEND = 1'b1;

endpackage : irq_pkg

`default_nettype wire

// File: rtl/irq_timer.sv
//------------------------------------------------------------------------------
// Module      : irq_timer
// Description : Loadable countdown timer with a single-cycle expire strobe.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module irq_timer #(
    parameter int TIMER_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [TIMER_WIDTH-1:0] load_value,
    output logic [TIMER_WIDTH-1:0] value,
    output logic                   expire
);

    logic [TIMER_WIDTH-1:0] r_value;

    // Expire fires on the edge where the count moves 1 -> 0; a load overrides it.
    assign expire = !load && (r_value == TIMER_WIDTH'(1));
    assign value  = r_value;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_value <= '0;
        end else if (load) begin
            r_value <= load_value;
        end else if (r_value != '0) begin
            r_value <= r_value - TIMER_WIDTH'(1);
        end
    end

endmodule : irq_timer

`default_nettype wire

// File: rtl/irq_ctrl.sv
//------------------------------------------------------------------------------
// Module      : irq_ctrl
// Description : Interrupt controller: pending/mask tracking, timer, dispatch FSM.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module irq_ctrl
    import irq_pkg::*;
#(
    parameter int          NUM_IRQ      = 32,
    parameter int          TIMER_WIDTH  = 32,
    parameter logic [31:0] MASKED_IRQ   = 32'h0,
    parameter logic [31:0] LATCHED_IRQ  = 32'hffff_ffff,
    parameter int          TIMER_IRQ    = 0,
    parameter logic [31:0] PROGADDR_IRQ = 32'h0000_0010
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_IRQ-1:0]     irq_in,
    input  logic                   boundary,
    input  logic [31:0]            next_pc,
    input  logic                   latched_compr,
    input  logic                   retirq,
    input  logic                   mask_wr,
    input  logic [NUM_IRQ-1:0]     mask_wdata,
    output logic [NUM_IRQ-1:0]     mask_rdata,
    input  logic                   timer_wr,
    input  logic [TIMER_WIDTH-1:0] timer_wdata,
    output logic [TIMER_WIDTH-1:0] timer_rdata,
    output logic                   redirect,
    output logic [31:0]            redirect_pc,
    output logic                   qreg_we,
    output logic                   qreg_idx,
    output logic [31:0]            qreg_wdata,
    output logic [NUM_IRQ-1:0]     eoi,
    output logic                   irq_active,
    output logic [NUM_IRQ-1:0]     pending
);

    irq_state_t         r_state;
    irq_state_t         w_state_next;
    logic [NUM_IRQ-1:0] r_mask;
    logic [NUM_IRQ-1:0] r_pend;
    logic [NUM_IRQ-1:0] r_eoi;
    logic               r_irq_delay;
    logic [NUM_IRQ-1:0] w_pend_next;
    logic [NUM_IRQ-1:0] w_serv;
    logic [NUM_IRQ-1:0] w_clear;
    logic [31:0]        w_serv_ext;
    logic               w_timer_expire;

    irq_timer #(
        .TIMER_WIDTH (TIMER_WIDTH)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_wr),
        .load_value (timer_wdata),
        .value      (timer_rdata),
        .expire     (w_timer_expire)
    );

    // Registered mask is the pre-write value, so a write during SAVE_PEND cannot alter the serviced set.
    assign w_serv  = r_pend & ~r_mask;
    assign w_clear = (r_state == ST_SAVE_PEND) ? w_serv : '0;

    always_comb begin
        w_serv_ext              = '0;
        w_serv_ext[NUM_IRQ-1:0] = w_serv;
    end

    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_chan
        if (MASKED_IRQ[i]) begin : g_masked
            assign w_pend_next[i] = 1'b0;
        end else if (i == TIMER_IRQ) begin : g_timer
            assign w_pend_next[i] = irq_in[i] | w_timer_expire | (r_pend[i] & ~w_clear[i]);
        end else if (LATCHED_IRQ[i]) begin : g_latched
            assign w_pend_next[i] = irq_in[i] | (r_pend[i] & ~w_clear[i]);
        end else begin : g_level
            assign w_pend_next[i] = irq_in[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_mask      <= '1;
            r_pend      <= '0;
            r_eoi       <= '0;
            r_irq_delay <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_pend      <= w_pend_next;
            r_irq_delay <= (r_state == ST_ACTIVE) && retirq;
            if (mask_wr) begin
                r_mask <= mask_wdata;
            end
            if (r_state == ST_SAVE_PEND) begin
                r_eoi <= w_serv;
            end else if ((r_state == ST_ACTIVE) && retirq) begin
                r_eoi <= '0;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        qreg_we      = 1'b0;
        qreg_idx     = QREG_PC;
        qreg_wdata   = '0;
        redirect     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (boundary && !r_irq_delay && |w_serv) begin
                    w_state_next = ST_SAVE_PC;
                end
            end
            ST_SAVE_PC: begin
                qreg_we      = 1'b1;
                qreg_idx     = QREG_PC;
                qreg_wdata   = next_pc | {31'b0, latched_compr};
                redirect     = 1'b1;
                w_state_next = ST_SAVE_PEND;
            end
            ST_SAVE_PEND: begin
                qreg_we      = 1'b1;
                qreg_idx     = QREG_PEND;
                qreg_wdata   = w_serv_ext;
                w_state_next = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (retirq) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign redirect_pc = PROGADDR_IRQ;
    assign mask_rdata  = r_mask;
    assign pending     = r_pend;
    assign eoi         = r_eoi;
    assign irq_active  = (r_state == ST_ACTIVE);

endmodule : irq_ctrl

`default_nettype wire

// File: tb/tb_irq_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_irq_ctrl
// Description : Directed self-checking bench for irq_ctrl.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_irq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] irq_in;
    logic        boundary;
    logic [31:0] next_pc;
    logic        latched_compr;
    logic        retirq;
    logic        mask_wr;
    logic [31:0] mask_wdata;
    logic [31:0] mask_rdata;
    logic        timer_wr;
    logic [31:0] timer_wdata;
    logic [31:0] timer_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        qreg_we;
    logic        qreg_idx;
    logic [31:0] qreg_wdata;
    logic [31:0] eoi;
    logic        irq_active;
    logic [31:0] pending;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    // Channel 3 is level-sensitive, channel 31 is permanently masked.
    irq_ctrl #(
        .NUM_IRQ      (32),
        .TIMER_WIDTH  (32),
        .MASKED_IRQ   (32'h8000_0000),
        .LATCHED_IRQ  (32'hffff_fff7),
        .TIMER_IRQ    (0),
        .PROGADDR_IRQ (32'h0000_0010)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .irq_in        (irq_in),
        .boundary      (boundary),
        .next_pc       (next_pc),
        .latched_compr (latched_compr),
        .retirq        (retirq),
        .mask_wr       (mask_wr),
        .mask_wdata    (mask_wdata),
        .mask_rdata    (mask_rdata),
        .timer_wr      (timer_wr),
        .timer_wdata   (timer_wdata),
        .timer_rdata   (timer_rdata),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .qreg_we       (qreg_we),
        .qreg_idx      (qreg_idx),
        .qreg_wdata    (qreg_wdata),
        .eoi           (eoi),
        .irq_active    (irq_active),
        .pending       (pending)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset         = 1'b1;
        irq_in        = '0;
        boundary      = 1'b0;
        next_pc       = '0;
        latched_compr = 1'b0;
        retirq        = 1'b0;
        mask_wr       = 1'b0;
        mask_wdata    = '0;
        timer_wr      = 1'b0;
        timer_wdata   = '0;

        tick();
        tick();
        check("rst_mask",     mask_rdata,  32'hffff_ffff);
        check("rst_pending",  pending,     32'h0);
        check("rst_eoi",      eoi,         32'h0);
        check("rst_timer",    timer_rdata, 32'h0);
        check("rst_qreg_we",  {31'b0, qreg_we},    32'h0);
        check("rst_redirect", {31'b0, redirect},   32'h0);
        check("rst_active",   {31'b0, irq_active}, 32'h0);
        check("redirect_pc",  redirect_pc, 32'h10);
        reset = 1'b0;

        // Single latched pulse on channel 5 with compressed return address
        mask_wr = 1'b1; mask_wdata = 32'h0;
        tick();
        mask_wr = 1'b0;
        check("mask_zero", mask_rdata, 32'h0);
        irq_in = 32'h20;
        tick();
        irq_in = 32'h0;
        check("p5_pending", pending, 32'h20);
        boundary = 1'b1; next_pc = 32'h100; latched_compr = 1'b1;
        tick();
        boundary = 1'b0;
        check("p5_redirect", {31'b0, redirect}, 32'h1);
        check("p5_q0_we",    {31'b0, qreg_we},  32'h1);
        check("p5_q0_idx",   {31'b0, qreg_idx}, 32'h0);
        check("p5_q0_data",  qreg_wdata,        32'h101);
        tick();
        check("p5_q1_we",    {31'b0, qreg_we},  32'h1);
        check("p5_q1_idx",   {31'b0, qreg_idx}, 32'h1);
        check("p5_q1_data",  qreg_wdata,        32'h20);
        check("p5_q1_redir", {31'b0, redirect}, 32'h0);
        tick();
        check("p5_eoi",      eoi,                 32'h20);
        check("p5_cleared",  pending,             32'h0);
        check("p5_active",   {31'b0, irq_active}, 32'h1);
        check("p5_act_we",   {31'b0, qreg_we},    32'h0);
        retirq = 1'b1;
        tick();
        retirq = 1'b0;
        check("p5_ret_eoi",    eoi,                 32'h0);
        check("p5_ret_active", {31'b0, irq_active}, 32'h0);

        // Timer countdown from 3 raises sticky channel 0
        latched_compr = 1'b0; next_pc = 32'h200;
        timer_wr = 1'b1; timer_wdata = 32'd3;
        tick();
        timer_wr = 1'b0;
        check("tmr_load", timer_rdata, 32'd3);
        tick();
        check("tmr_2", timer_rdata, 32'd2);
        tick();
        check("tmr_1", timer_rdata, 32'd1);
        check("tmr_nopend", pending, 32'h0);
        tick();
        check("tmr_0", timer_rdata, 32'd0);
        check("tmr_pend", pending, 32'h1);
        tick();
        check("tmr_stay0", timer_rdata, 32'd0);
        check("tmr_sticky", pending, 32'h1);
        boundary = 1'b1;
        tick();
        boundary = 1'b0;
        check("tmr_q0_data", qreg_wdata, 32'h200);
        tick();
        check("tmr_q1_data", qreg_wdata, 32'h1);
        tick();
        check("tmr_eoi", eoi, 32'h1);
        check("tmr_cleared", pending, 32'h0);
        retirq = 1'b1;
        tick();
        retirq = 1'b0;
        tick();

        // Level channel 3 held high through return: delayed one cycle
        irq_in = 32'h8; boundary = 1'b1;
        tick();
        check("lvl_pending", pending, 32'h8);
        check("lvl_nodisp_yet", {31'b0, redirect}, 32'h0);
        tick();
        check("lvl_redirect", {31'b0, redirect}, 32'h1);
        tick();
        check("lvl_q1_data", qreg_wdata, 32'h8);
        tick();
        check("lvl_eoi", eoi, 32'h8);
        check("lvl_kept", pending, 32'h8);
        retirq = 1'b1;
        tick();
        retirq = 1'b0;
        check("lvl_ret_active", {31'b0, irq_active}, 32'h0);
        check("lvl_ret_eoi", eoi, 32'h0);
        tick();
        check("lvl_delay_redir", {31'b0, redirect}, 32'h0);
        check("lvl_delay_we",    {31'b0, qreg_we},  32'h0);
        tick();
        check("lvl_redispatch", {31'b0, redirect}, 32'h1);
        tick();
        tick();
        check("lvl_active2", {31'b0, irq_active}, 32'h1);
        irq_in = 32'h0; boundary = 1'b0; retirq = 1'b1;
        tick();
        retirq = 1'b0;
        tick();
        check("lvl_dropped", pending, 32'h0);

        // Masking: channel 1 pends but never dispatches; channel 31 never pends
        mask_wr = 1'b1; mask_wdata = 32'hffff_ffff;
        tick();
        mask_wdata = 32'hffff_fffe; irq_in = 32'h8000_0002; boundary = 1'b1;
        #1;
        check("msk_prewrite", mask_rdata, 32'hffff_ffff);
        tick();
        mask_wr = 1'b0;
        check("msk_written", mask_rdata, 32'hffff_fffe);
        check("msk_pending", pending, 32'h2);
        tick();
        check("msk_nodisp", {31'b0, redirect}, 32'h0);
        check("msk_idle", {31'b0, irq_active}, 32'h0);
        irq_in = 32'h0;
        tick();
        check("msk_latched", pending, 32'h2);

        // Reset asserted in SAVE_PC abandons the dispatch
        mask_wr = 1'b1; mask_wdata = 32'h0;
        tick();
        mask_wr = 1'b0;
        tick();
        check("rstd_redirect_in", {31'b0, redirect}, 32'h1);
        check("rstd_q0_data", qreg_wdata, 32'h200);
        #2;
        reset = 1'b1;
        #1;
        check("rstd_redirect", {31'b0, redirect},   32'h0);
        check("rstd_qreg_we",  {31'b0, qreg_we},    32'h0);
        check("rstd_eoi",      eoi,                 32'h0);
        check("rstd_mask",     mask_rdata,          32'hffff_ffff);
        check("rstd_pending",  pending,             32'h0);
        check("rstd_active",   {31'b0, irq_active}, 32'h0);
        tick();
        reset = 1'b0;
        tick();
        check("rstd_after_we",    {31'b0, qreg_we},  32'h0);
        check("rstd_after_redir", {31'b0, redirect}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_irq_ctrl

`default_nettype wire
